// File: rtl/ysyx_22050518_exu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22050518_exu_ctrl_pkg
//  Description : Shared types and constants for the execute-stage controller:
//                controller state encoding, operand-select codes, the ALU
//                opcodes shared with the fused ALU, and the div/rem decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22050518_exu_ctrl_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } exu_state_t;

    // Operand 0 select codes (11 reads as zero)
    localparam logic [1:0] c_SRC1_RS1  = 2'b00;
    localparam logic [1:0] c_SRC1_PC   = 2'b01;
    localparam logic [1:0] c_SRC1_ZERO = 2'b10;

    // Operand 1 select codes (11 reads as zero)
    localparam logic [1:0] c_SRC2_RS2  = 2'b00;
    localparam logic [1:0] c_SRC2_IMM  = 2'b01;
    localparam logic [1:0] c_SRC2_FOUR = 2'b10;

    // ALU opcodes; bit 6 selects the 32-bit word variant
    localparam logic [6:0] c_ALU_ADD  = 7'b000_0000;
    localparam logic [6:0] c_ALU_SUB  = 7'b000_0001;
    localparam logic [6:0] c_ALU_DIV  = 7'b001_1100;
    localparam logic [6:0] c_ALU_DIVU = 7'b001_1101;
    localparam logic [6:0] c_ALU_REM  = 7'b001_1110;
    localparam logic [6:0] c_ALU_REMU = 7'b001_1111;
    localparam logic [6:0] c_ALU_WORD = 7'b100_0000;

    // Div/rem family (word or double) is identified by opcode bits [4:2]
    function automatic logic is_div(input logic [2:0] i_op_4_2);
        return (i_op_4_2 == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050518_exu_opsel.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22050518_exu_opsel
//  Description : Combinational ALU operand selector driven by the decoded
//                src1/src2 select fields.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050518_exu_opsel
    import ysyx_22050518_exu_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      i_src1_sel,
    input  logic [1:0]      i_src2_sel,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    output logic [XLEN-1:0] o_in0,
    output logic [XLEN-1:0] o_in1
);

    // Operand muxes; the reserved code 11 and the explicit zero code give 0
    always_comb begin
        o_in0 = '0;
        o_in1 = '0;
        case (i_src1_sel)
            c_SRC1_RS1:  o_in0 = i_rs1;
            c_SRC1_PC:   o_in0 = i_pc;
            c_SRC1_ZERO: o_in0 = '0;
            default:     o_in0 = '0;
        endcase
        case (i_src2_sel)
            c_SRC2_RS2:  o_in1 = i_rs2;
            c_SRC2_IMM:  o_in1 = i_imm;
            c_SRC2_FOUR: o_in1 = XLEN'(4);
            default:     o_in1 = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22050518_exu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22050518_exu_ctrl
//  Description : Execute-stage controller in front of the fused ALU. Accepts
//                ID bundles, issues operands to the ALU, waits out div/rem,
//                presents a registered result to MEM, and handles flush
//                (including draining a divider that cannot be aborted).
//                Optional macro EXU_PERF_EN adds three 64-bit perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050518_exu_ctrl
    import ysyx_22050518_exu_ctrl_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int DIV_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_val,
    input  logic [XLEN-1:0] id_rs2_val,
    input  logic [XLEN-1:0] id_imm,
    input  logic [1:0]      id_src1_sel,
    input  logic [1:0]      id_src2_sel,
    input  logic [6:0]      id_alu_op,
    input  logic [4:0]      id_rd,
    input  logic            id_wen,
    output logic [XLEN-1:0] alu_in0,
    output logic [XLEN-1:0] alu_in1,
    output logic [6:0]      alu_op,
    output logic            alu_en,
    input  logic            alu_valid,
    input  logic            alu_ready,
    input  logic [XLEN-1:0] alu_out,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_result,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic            ex_wen,
    output logic            err_timeout
`ifdef EXU_PERF_EN
    ,
    output logic [63:0]     perf_busy_cyc,
    output logic [63:0]     perf_div_wait_cyc,
    output logic [63:0]     perf_retired
`endif
);

    localparam logic [31:0] c_TMO = 32'(DIV_TIMEOUT);

    exu_state_t        r_state;
    logic [XLEN-1:0]   r_alu_in0;
    logic [XLEN-1:0]   r_alu_in1;
    logic [6:0]        r_alu_op;
    logic [XLEN-1:0]   r_pc;
    logic [4:0]        r_rd;
    logic              r_wen;
    logic [XLEN-1:0]   r_result;
    logic [31:0]       r_to_cnt;
    logic              r_err;

    logic [XLEN-1:0]   w_in0;
    logic [XLEN-1:0]   w_in1;
    logic              w_id_ready;
    logic              w_accept;
    logic              w_in_wait;
    logic              w_op_is_div;
    logic [31:0]       w_to_next;

    ysyx_22050518_exu_opsel #(
        .XLEN (XLEN)
    ) u_opsel (
        .i_src1_sel (id_src1_sel),
        .i_src2_sel (id_src2_sel),
        .i_rs1      (id_rs1_val),
        .i_rs2      (id_rs2_val),
        .i_pc       (id_pc),
        .i_imm      (id_imm),
        .o_in0      (w_in0),
        .o_in1      (w_in1)
    );

    // Ready is only offered from IDLE, or from DONE when MEM takes the result;
    // a flush cycle never accepts.
    always_comb begin
        w_id_ready = 1'b0;
        case (r_state)
            ST_IDLE: w_id_ready = ~flush;
            ST_DONE: w_id_ready = ex_ready & ~flush;
            default: w_id_ready = 1'b0;
        endcase
    end

    assign w_accept    = id_valid & w_id_ready;
    assign w_in_wait   = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
    assign w_op_is_div = is_div(r_alu_op[4:2]);
    assign w_to_next   = r_to_cnt + 32'd1;

    // Main controller: bundle capture, result capture and state sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_alu_in0 <= '0;
            r_alu_in1 <= '0;
            r_alu_op  <= '0;
            r_pc      <= '0;
            r_rd      <= '0;
            r_wen     <= 1'b0;
            r_result  <= '0;
        end else begin
            if (w_accept) begin
                r_alu_in0 <= w_in0;
                r_alu_in1 <= w_in1;
                r_alu_op  <= id_alu_op;
                r_pc      <= id_pc;
                r_rd      <= id_rd;
                r_wen     <= id_wen;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (alu_ready) begin
                        if (!w_op_is_div) begin
                            r_result <= alu_out;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state  <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // A flushed divide must still be drained unless it
                    // completes in this very cycle.
                    if (flush) begin
                        r_state <= alu_valid ? ST_IDLE : ST_DRAIN;
                    end else if (alu_valid) begin
                        r_result <= alu_out;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (ex_ready) begin
                        r_state <= w_accept ? ST_ISSUE : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (alu_valid) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Divider watchdog: counts consecutive WAIT/DRAIN cycles, flags sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_in_wait) begin
                if (r_to_cnt != '1) r_to_cnt <= w_to_next;
            end else begin
                r_to_cnt <= '0;
            end
            if ((c_TMO != 32'd0) && w_in_wait && (w_to_next >= c_TMO)) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef EXU_PERF_EN
    logic [63:0] r_perf_busy;
    logic [63:0] r_perf_wait;
    logic [63:0] r_perf_ret;

    // Free-running performance counters, wrapping naturally at 2^64
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_busy <= '0;
            r_perf_wait <= '0;
            r_perf_ret  <= '0;
        end else begin
            if (r_state != ST_IDLE)                r_perf_busy <= r_perf_busy + 64'd1;
            if (w_in_wait)                         r_perf_wait <= r_perf_wait + 64'd1;
            if ((r_state == ST_DONE) && ex_ready)  r_perf_ret  <= r_perf_ret + 64'd1;
        end
    end

    assign perf_busy_cyc     = r_perf_busy;
    assign perf_div_wait_cyc = r_perf_wait;
    assign perf_retired      = r_perf_ret;
`endif

    assign id_ready    = w_id_ready;
    assign alu_in0     = r_alu_in0;
    assign alu_in1     = r_alu_in1;
    assign alu_op      = r_alu_op;
    assign alu_en      = (r_state == ST_ISSUE) & alu_ready & ~flush;
    assign ex_valid    = (r_state == ST_DONE);
    assign ex_result   = r_result;
    assign ex_pc       = r_pc;
    assign ex_rd       = r_rd;
    assign ex_wen      = r_wen;
    assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050518_exu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_22050518_exu_ctrl
//  Description : Self-checking bench for the execute-stage controller with a
//                behavioural ALU (combinational add/sub, multi-cycle div/rem).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050518_exu_ctrl;

    localparam int XLEN = 64;
    localparam int TMO  = 20;

    localparam logic [6:0] OP_ADD  = 7'h00;
    localparam logic [6:0] OP_SUB  = 7'h01;
    localparam logic [6:0] OP_DIVU = 7'h1D;
    localparam logic [6:0] OP_REMU = 7'h1F;

    logic            clk = 1'b0;
    logic            rst, flush, id_valid, id_ready;
    logic [63:0]     id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [1:0]      id_src1_sel, id_src2_sel;
    logic [6:0]      id_alu_op;
    logic [4:0]      id_rd;
    logic            id_wen;
    logic [63:0]     alu_in0, alu_in1, alu_out;
    logic [6:0]      alu_op;
    logic            alu_en, alu_valid, alu_ready;
    logic            ex_valid, ex_ready;
    logic [63:0]     ex_result, ex_pc;
    logic [4:0]      ex_rd;
    logic            ex_wen, err_timeout;
`ifdef EXU_PERF_EN
    logic [63:0]     perf_busy_cyc, perf_div_wait_cyc, perf_retired;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_22050518_exu_ctrl #(.XLEN(XLEN), .DIV_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel),
        .id_alu_op(id_alu_op), .id_rd(id_rd), .id_wen(id_wen),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op), .alu_en(alu_en),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_out(alu_out),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
        .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_wen(ex_wen), .err_timeout(err_timeout)
`ifdef EXU_PERF_EN
        , .perf_busy_cyc(perf_busy_cyc), .perf_div_wait_cyc(perf_div_wait_cyc),
        .perf_retired(perf_retired)
`endif
    );

    // ---------------- reference functions ----------------
    function automatic logic m_is_div(input logic [6:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic [63:0] m_alu(input logic [6:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_DIVU: return (b == 64'd0) ? '1 : a / b;
            OP_REMU: return (b == 64'd0) ? a : a % b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] m_opa(input logic [1:0] s, input logic [63:0] rs1, input logic [63:0] pc);
        if (s == 2'd0) return rs1;
        if (s == 2'd1) return pc;
        return 64'd0;
    endfunction

    function automatic logic [63:0] m_opb(input logic [1:0] s, input logic [63:0] rs2, input logic [63:0] imm);
        if (s == 2'd0) return rs2;
        if (s == 2'd1) return imm;
        if (s == 2'd2) return 64'd4;
        return 64'd0;
    endfunction

    // ---------------- behavioural ALU ----------------
    int          div_lat = 10;
    logic [31:0] div_cnt;
    logic [63:0] div_res;
    int          en_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            div_cnt <= 0;
        end else if (alu_en && m_is_div(alu_op)) begin
            div_cnt <= 32'(div_lat);
            div_res <= m_alu(alu_op, alu_in0, alu_in1);
        end else if (div_cnt != 0) begin
            div_cnt <= div_cnt - 1;
        end
        if (alu_en) en_cnt <= en_cnt + 1;
    end

    assign alu_valid = (div_cnt == 32'd1);
    assign alu_out   = (div_cnt != 0) ? div_res : m_alu(alu_op, alu_in0, alu_in1);

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s1, input logic [1:0] s2, input logic [63:0] rs1,
                         input logic [63:0] rs2, input logic [63:0] pc, input logic [63:0] imm,
                         input logic [6:0] op, input logic [4:0] rd);
        id_src1_sel = s1; id_src2_sel = s2; id_rs1_val = rs1; id_rs2_val = rs2;
        id_pc = pc; id_imm = imm; id_alu_op = op; id_rd = rd; id_wen = 1'b1;
    endtask

    task automatic retire();
        ex_ready = 1'b1;
        @(negedge clk);
        ex_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  s1, s2;
        logic [63:0] rs1, rs2, pc, imm;
        logic [6:0]  op;
        logic [63:0] e_in0, e_in1, e_res;
    } vec_t;

    vec_t vt[6];

    // ---------------- random test with scoreboard ----------------
    task automatic run_random(input int n);
        logic [63:0] q_res[$];
        logic [63:0] q_pc[$];
        int issued = 0, retired = 0, cyc = 0;
        logic took = 1'b0;
        logic [1:0] s1, s2;
        logic [6:0] op;
        logic [63:0] r1, r2, pc, im;
        while (retired < n && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (took) id_valid = 1'b0;
            took = 1'b0;
            if (!id_valid && issued < n && $urandom_range(0, 3) != 0) begin
                s1 = 2'($urandom_range(0, 3)); s2 = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0: op = OP_ADD; 1: op = OP_SUB; 2: op = OP_DIVU; default: op = OP_REMU;
                endcase
                r1 = {$urandom, $urandom}; r2 = {32'd0, $urandom};
                pc = {$urandom, $urandom}; im = {$urandom, $urandom};
                drive(s1, s2, r1, r2, pc, im, op, 5'($urandom));
                id_valid = 1'b1;
            end
            ex_ready  = ($urandom_range(0, 2) != 0);
            alu_ready = ($urandom_range(0, 3) != 0);
            div_lat   = $urandom_range(1, 12);
            #1;
            if (ex_valid && ex_ready) begin
                if (q_res.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rnd_unexpected_retire: got result 0x%0h expected none", ex_result);
                end else begin
                    chk("rnd_result", ex_result, q_res.pop_front());
                    chk("rnd_pc", ex_pc, q_pc.pop_front());
                end
                retired++;
            end
            if (id_valid && id_ready) begin
                q_res.push_back(m_alu(id_alu_op, m_opa(id_src1_sel, id_rs1_val, id_pc),
                                      m_opb(id_src2_sel, id_rs2_val, id_imm)));
                q_pc.push_back(id_pc);
                issued++;
                took = 1'b1;
            end
        end
        @(negedge clk);
        id_valid = 1'b0; ex_ready = 1'b0; alu_ready = 1'b1; div_lat = 10;
        chk("rnd_retired", 64'(retired), 64'(n));
        chk("rnd_queue_empty", 64'(q_res.size()), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int en0, seen_v, seen_x;
        logic flag;

        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0; alu_ready = 1'b1;
        drive(2'd0, 2'd0, 64'd0, 64'd0, 64'd0, 64'd0, OP_ADD, 5'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_id_ready", id_ready, 1'b1);
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_alu_en", alu_en, 1'b0);
        chk("rst_alu_in0", alu_in0, 64'd0);
        chk("rst_ex_result", ex_result, 64'd0);
        chk("rst_err", err_timeout, 1'b0);

        // ---- table-driven single-cycle ops ----
        vt[0] = '{2'd0, 2'd0, 64'd5, 64'd7, 64'h10, 64'd0, OP_ADD, 64'd5, 64'd7, 64'd12};
        vt[1] = '{2'd1, 2'd2, 64'd9, 64'd9, 64'h8000_0000, 64'd0, OP_ADD, 64'h8000_0000, 64'd4, 64'h8000_0004};
        vt[2] = '{2'd2, 2'd1, 64'd3, 64'd3, 64'h20, 64'hFFFF_FFFF_FFFF_FFF0, OP_ADD, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF0};
        vt[3] = '{2'd3, 2'd3, 64'd11, 64'd22, 64'h30, 64'd33, OP_ADD, 64'd0, 64'd0, 64'd0};
        vt[4] = '{2'd0, 2'd0, 64'd100, 64'd30, 64'h40, 64'd0, OP_SUB, 64'd100, 64'd30, 64'd70};
        vt[5] = '{2'd0, 2'd3, 64'h1234, 64'd77, 64'h50, 64'd88, OP_SUB, 64'h1234, 64'd0, 64'h1234};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(vt[i].s1, vt[i].s2, vt[i].rs1, vt[i].rs2, vt[i].pc, vt[i].imm, vt[i].op, 5'(i + 1));
            id_valid = 1'b1;
            #1 chk("vec_ready_idle", id_ready, 1'b1);
            @(negedge clk);
            id_valid = 1'b0;
            #1;
            chk("vec_ready_issue", id_ready, 1'b0);
            chk("vec_alu_en", alu_en, 1'b1);
            chk("vec_in0", alu_in0, vt[i].e_in0);
            chk("vec_in1", alu_in1, vt[i].e_in1);
            chk("vec_ex_valid_t1", ex_valid, 1'b0);
            @(negedge clk);
            #1;
            chk("vec_ex_valid_t2", ex_valid, 1'b1);
            chk("vec_result", ex_result, vt[i].e_res);
            chk("vec_pc", ex_pc, vt[i].pc);
            chk("vec_rd", ex_rd, 64'(i + 1));
            retire();
            #1 chk("vec_ex_valid_after", ex_valid, 1'b0);
        end

        // ---- divu 100/7, ALU valid 10 cycles after start ----
        div_lat = 10; en0 = en_cnt;
        @(negedge clk);
        drive(2'd0, 2'd0, 64'd100, 64'd7, 64'h200, 64'd0, OP_DIVU, 5'd9);
        id_valid = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        #1 chk("div_alu_en_issue", alu_en, 1'b1);
        seen_v = -1; seen_x = -1; flag = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk); #1;
            if (ex_valid) begin seen_x = c; break; end
            if (id_ready) flag = 1'b1;
            if (alu_valid) seen_v = c;
        end
        chk("div_en_pulses", 64'(en_cnt - en0), 64'd1);
        chk("div_ready_low_wait", flag, 1'b0);
        chk("div_alu_valid_cycle", 64'(seen_v), 64'd10);
        chk("div_ex_valid_cycle", 64'(seen_x), 64'd11);
        chk("div_result", ex_result, 64'd14);
        retire();

        // ---- MEM backpressure then back-to-back accept ----
        @(negedge clk);
        drive(2'd0, 2'd0, 64'd1, 64'd2, 64'h100, 64'd0, OP_ADD, 5'd3);
        id_valid = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        flag = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                drive(2'd0, 2'd0, 64'd10, 64'd20, 64'h200, 64'd0, OP_ADD, 5'd4);
                id_valid = 1'b1;
            end
            #1;
            if (!ex_valid || ex_result !== 64'd3 || ex_pc !== 64'h100 || ex_rd !== 5'd3 || id_ready)
                flag = 1'b1;
        end
        chk("bp_stable", flag, 1'b0);
        @(negedge clk);
        ex_ready = 1'b1;
        #1 chk("bp_ready_release", id_ready, 1'b1);
        @(negedge clk);
        id_valid = 1'b0; ex_ready = 1'b0;
        #1;
        chk("b2b_ex_valid_issue", ex_valid, 1'b0);
        chk("b2b_alu_en", alu_en, 1'b1);
        chk("b2b_in0", alu_in0, 64'd10);
        @(negedge clk); #1;
        chk("b2b_result", ex_result, 64'd30);
        chk("b2b_pc", ex_pc, 64'h200);
        retire();

        // ---- flush during WAIT (third divide cycle) -> drain ----
        div_lat = 10; en0 = en_cnt;
        @(negedge clk);
        drive(2'd0, 2'd0, 64'd50, 64'd5, 64'h300, 64'd0, OP_DIVU, 5'd5);
        id_valid = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1; id_valid = 1'b1;
        #1 chk("flw_ready_flush", id_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0; id_valid = 1'b0;
        #1;
        flag = 1'b0; seen_v = 0;
        for (int c = 0; c < 20; c++) begin
            if (ex_valid || id_ready) flag = 1'b1;
            if (alu_valid) begin seen_v = 1; break; end
            @(negedge clk); #1;
        end
        chk("flw_drain_quiet", flag, 1'b0);
        chk("flw_alu_valid_seen", 64'(seen_v), 64'd1);
        @(negedge clk); #1;
        chk("flw_ready_after", id_ready, 1'b1);
        chk("flw_ex_valid_after", ex_valid, 1'b0);
        chk("flw_en_pulses", 64'(en_cnt - en0), 64'd1);

        // ---- flush in ISSUE with alu_ready=1 ----
        en0 = en_cnt;
        @(negedge clk);
        drive(2'd0, 2'd0, 64'd4, 64'd4, 64'h400, 64'd0, OP_ADD, 5'd6);
        id_valid = 1'b1;
        @(negedge clk);
        flush = 1'b1; alu_ready = 1'b1;
        #1;
        chk("fli_alu_en", alu_en, 1'b0);
        chk("fli_ready", id_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0; id_valid = 1'b0;
        #1;
        chk("fli_idle_ready", id_ready, 1'b1);
        chk("fli_no_issue", alu_en, 1'b0);
        @(negedge clk); #1;
        chk("fli_ex_valid", ex_valid, 1'b0);
        chk("fli_en_pulses", 64'(en_cnt - en0), 64'd0);

        // ---- randomized traffic against the scoreboard ----
        run_random(150);

        // ---- reset in the middle of a divide ----
        div_lat = 10;
        @(negedge clk);
        drive(2'd1, 2'd2, 64'd0, 64'd0, 64'h8000_0000, 64'd0, OP_DIVU, 5'd7);
        id_valid = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rmw_id_ready", id_ready, 1'b1);
        chk("rmw_outputs_zero", {alu_in0 | alu_in1 | ex_result | ex_pc},
            64'd0);
        chk("rmw_ctrl_zero", {alu_op, ex_rd, alu_en, ex_valid, ex_wen, err_timeout}, 64'd0);

        // ---- watchdog: divide longer than the limit ----
        div_lat = 25;
        @(negedge clk);
        drive(2'd0, 2'd0, 64'd1000, 64'd10, 64'h500, 64'd0, OP_DIVU, 5'd8);
        id_valid = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1 chk("tmo_not_yet", err_timeout, 1'b0);
        seen_x = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (ex_valid) begin seen_x = 1; break; end
        end
        chk("tmo_completed", 64'(seen_x), 64'd1);
        chk("tmo_result", ex_result, 64'd100);
        chk("tmo_set", err_timeout, 1'b1);
        retire();
        repeat (3) @(negedge clk);
        #1 chk("tmo_sticky", err_timeout, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("tmo_cleared", err_timeout, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
